// File: rtl/memory_bus_responder_if.sv
// Request/response bus between a bus master and the memory responder.
// master: drives request slot and resp_busy; slave: the responder side.
interface memory_bus_responder_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int ID_W   = 4
);
    logic              req_busy;
    logic [1:0]        req_type;
    logic [ID_W-1:0]   req_source;
    logic [ADDR_W-1:0] req_address;
    logic [DATA_W-1:0] req_payload;
    logic              req_accept;
    logic              resp_busy;
    logic              resp_send;
    logic [1:0]        resp_type;
    logic [ID_W-1:0]   resp_source;
    logic [ADDR_W-1:0] resp_address;
    logic [DATA_W-1:0] resp_payload;

    modport master (
        output req_busy, req_type, req_source,
        output req_address, req_payload, resp_busy,
        input  req_accept, resp_send, resp_type,
        input  resp_source, resp_address, resp_payload
    );

    modport slave (
        input  req_busy, req_type, req_source,
        input  req_address, req_payload, resp_busy,
        output req_accept, resp_send, resp_type,
        output resp_source, resp_address, resp_payload
    );
endinterface

// File: rtl/memory_bus_responder.sv
// Single-outstanding memory responder: accepts reads/writes, answers reads.
// Ports: clk, reset_n (async low), bus (slave side), error_count (saturating).
module memory_bus_responder #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 64,
    parameter int ID_W         = 4,
    parameter int MEM_WORDS    = 256,
    parameter int READ_LATENCY = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    memory_bus_responder_if.slave  bus,
    output logic [7:0]             error_count
);
    localparam int IDX_W = $clog2(MEM_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        WAIT,
        RESP
    } state_t;

    state_t            state;
    logic [1:0]        lat_type;
    logic [ID_W-1:0]   lat_src;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_data;
    logic [3:0]        lat_cnt;

    logic [DATA_W-1:0] mem [MEM_WORDS];

    logic              in_range;
    logic [IDX_W-1:0]  idx;
    logic              is_err;
    logic              do_write;

    assign idx      = lat_addr[IDX_W-1:0];
    assign in_range = (lat_addr >> IDX_W) == '0;
    // Types 2/3 and out-of-range addresses count once each.
    assign is_err   = lat_type[1] || !in_range;
    assign do_write = (state == EXEC) && (lat_type == 2'd1) && in_range;

    // Sent in the same cycle resp_busy is seen low so the bus
    // can load the slot on that edge.
    assign bus.resp_send = (state == RESP) && !bus.resp_busy;

    // Backing store is deliberately not reset.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[idx] <= lat_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            lat_type         <= '0;
            lat_src          <= '0;
            lat_addr         <= '0;
            lat_data         <= '0;
            lat_cnt          <= '0;
            error_count      <= '0;
            bus.req_accept   <= 1'b0;
            bus.resp_type    <= '0;
            bus.resp_source  <= '0;
            bus.resp_address <= '0;
            bus.resp_payload <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    bus.req_accept <= 1'b0;
                    if (bus.req_busy) begin
                        lat_type       <= bus.req_type;
                        lat_src        <= bus.req_source;
                        lat_addr       <= bus.req_address;
                        lat_data       <= bus.req_payload;
                        bus.req_accept <= 1'b1;
                        state          <= EXEC;
                    end
                end
                EXEC: begin
                    bus.req_accept <= 1'b0;
                    if (is_err && error_count != 8'hFF) begin
                        error_count <= error_count + 8'd1;
                    end
                    if (lat_type == 2'd0) begin
                        bus.resp_type    <= 2'd2;
                        bus.resp_source  <= lat_src;
                        bus.resp_address <= '0;
                        bus.resp_payload <= in_range ? mem[idx] : '0;
                        lat_cnt          <= 4'(READ_LATENCY - 1);
                        if (READ_LATENCY == 1) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT: begin
                    bus.req_accept <= 1'b0;
                    lat_cnt        <= lat_cnt - 4'd1;
                    if (lat_cnt == 4'd1) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    bus.req_accept <= 1'b0;
                    if (!bus.resp_busy) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    bus.req_accept <= 1'b0;
                    state          <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_memory_bus_responder.sv
// Testbench for memory_bus_responder: vector table, hand sequences, random ops.
// Ports driven through a master-side interface instance.
module tb_memory_bus_responder;
    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] error_count;

    memory_bus_responder_if bus ();

    memory_bus_responder dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus.slave),
        .error_count (error_count)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [63:0] mdl [256];
    bit          vld [256];
    int          err_m = 0;

    typedef struct {
        logic [1:0]  typ;
        logic [3:0]  src;
        logic [31:0] addr;
        logic [63:0] pay;
        bit          exp_send;
        logic [63:0] exp_data;
        logic [7:0]  exp_err;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference behaviour: word store, saturating error tally.
    task automatic model(input logic [1:0] typ, input logic [31:0] addr,
                         input logic [63:0] pay, output bit es,
                         output logic [63:0] ed);
        bit inr;
        inr = addr < 256;
        es  = 1'b0;
        ed  = '0;
        if (typ >= 2 || !inr) err_m = (err_m >= 255) ? 255 : err_m + 1;
        if (typ == 1 && inr) begin
            mdl[addr[7:0]] = pay;
            vld[addr[7:0]] = 1'b1;
        end
        if (typ == 0) begin
            es = 1'b1;
            ed = inr ? mdl[addr[7:0]] : 64'd0;
        end
    endtask

    task automatic issue(input logic [1:0] typ, input logic [3:0] src,
                         input logic [31:0] addr, input logic [63:0] pay,
                         output int n_acc, output int n_snd,
                         output int dly, output logic [1:0] rt,
                         output logic [3:0] rs, output logic [31:0] ra,
                         output logic [63:0] rp);
        int acc_at;
        n_acc  = 0;
        n_snd  = 0;
        dly    = -1;
        acc_at = -1;
        rt = '0; rs = '0; ra = '0; rp = '0;
        @(negedge clk);
        bus.req_busy    = 1'b1;
        bus.req_type    = typ;
        bus.req_source  = src;
        bus.req_address = addr;
        bus.req_payload = pay;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            #1;
            if (bus.req_accept) begin
                n_acc++;
                if (acc_at < 0) begin
                    acc_at = cyc;
                    bus.req_busy = 1'b0;
                end
            end
            if (bus.resp_send) begin
                n_snd++;
                if (dly < 0) begin
                    dly = cyc - acc_at;
                    rt = bus.resp_type;
                    rs = bus.resp_source;
                    ra = bus.resp_address;
                    rp = bus.resp_payload;
                end
            end
        end
        bus.req_busy = 1'b0;
    endtask

    task automatic op(input logic [1:0] typ, input logic [3:0] src,
                      input logic [31:0] addr, input logic [63:0] pay,
                      input string nm);
        bit es;
        logic [63:0] ed;
        int na, ns, dl;
        logic [1:0] rt;
        logic [3:0] rs;
        logic [31:0] ra;
        logic [63:0] rp;
        model(typ, addr, pay, es, ed);
        issue(typ, src, addr, pay, na, ns, dl, rt, rs, ra, rp);
        chk({nm, "_acc"}, 64'(na), 64'd1);
        chk({nm, "_send"}, 64'(ns), 64'(es));
        if (es && ns == 1) begin
            chk({nm, "_dly"}, 64'(dl), 64'd2);
            chk({nm, "_type"}, 64'(rt), 64'd2);
            chk({nm, "_src"}, 64'(rs), 64'(src));
            chk({nm, "_addr"}, 64'(ra), 64'd0);
            chk({nm, "_data"}, rp, ed);
        end
        chk({nm, "_err"}, 64'(error_count), 64'(err_m));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        err_m = 0;
    endtask

    task automatic wait_acc(input string nm);
        bit got;
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            #1;
            if (bus.req_accept) got = 1'b1;
        end
        chk({nm, "_acc"}, 64'(got), 64'd1);
    endtask

    initial begin
        bit es;
        logic [63:0] ed;
        int na, ns, dl, acc2, snd;
        logic [1:0] rt;
        logic [3:0] rs;
        logic [31:0] ra;
        logic [63:0] rp;
        logic [1:0] typ;
        logic [31:0] addr;

        tbl[0] = '{2'd1, 4'd2, 32'd10, 64'h1111_2222_3333_4444, 0, 64'd0, 8'd0};
        tbl[1] = '{2'd0, 4'd4, 32'd10, 64'd0, 1, 64'h1111_2222_3333_4444, 8'd0};
        tbl[2] = '{2'd1, 4'd5, 32'd255, 64'hFFFF_0000_A5A5_5A5A, 0, 64'd0, 8'd0};
        tbl[3] = '{2'd0, 4'd6, 32'd255, 64'd0, 1, 64'hFFFF_0000_A5A5_5A5A, 8'd0};
        tbl[4] = '{2'd0, 4'd7, 32'd256, 64'd0, 1, 64'd0, 8'd1};
        tbl[5] = '{2'd3, 4'd8, 32'd3, 64'd7, 0, 64'd0, 8'd2};
        tbl[6] = '{2'd1, 4'd9, 32'd0, 64'h0123_4567_89AB_CDEF, 0, 64'd0, 8'd2};
        tbl[7] = '{2'd0, 4'd15, 32'd0, 64'd0, 1, 64'h0123_4567_89AB_CDEF, 8'd2};
        tbl[8] = '{2'd1, 4'd1, 32'd1000, 64'd1, 0, 64'd0, 8'd3};
        tbl[9] = '{2'd0, 4'd0, 32'd10, 64'd0, 1, 64'h1111_2222_3333_4444, 8'd3};

        reset_n         = 1'b0;
        bus.req_busy    = 1'b0;
        bus.req_type    = '0;
        bus.req_source  = '0;
        bus.req_address = '0;
        bus.req_payload = '0;
        bus.resp_busy   = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_accept", 64'(bus.req_accept), 64'd0);
        chk("rst_send", 64'(bus.resp_send), 64'd0);
        chk("rst_rtype", 64'(bus.resp_type), 64'd0);
        chk("rst_rsrc", 64'(bus.resp_source), 64'd0);
        chk("rst_raddr", 64'(bus.resp_address), 64'd0);
        chk("rst_rdata", bus.resp_payload, 64'd0);
        chk("rst_err", 64'(error_count), 64'd0);
        reset_n = 1'b1;

        // Out-of-range accesses: read gives 0, write leaves store alone.
        op(2'd1, 4'd1, 32'd44, 64'h4444_0000_0000_4444, "oor_pre");
        op(2'd0, 4'd1, 32'd300, 64'd0, "oor_rd");
        op(2'd1, 4'd1, 32'd300, 64'hBAD0_BAD0_BAD0_BAD0, "oor_wr");
        chk("oor_err2", 64'(error_count), 64'd2);
        op(2'd0, 4'd2, 32'd44, 64'd0, "oor_chk");
        op(2'd2, 4'd2, 32'd5, 64'd0, "illegal_t2");

        // Write then read of address 5.
        op(2'd1, 4'd1, 32'd5, 64'hDEAD, "wr5");
        op(2'd0, 4'd3, 32'd5, 64'd0, "rd5");

        do_reset();
        for (int i = 0; i < 10; i++) begin
            model(tbl[i].typ, tbl[i].addr, tbl[i].pay, es, ed);
            issue(tbl[i].typ, tbl[i].src, tbl[i].addr, tbl[i].pay,
                  na, ns, dl, rt, rs, ra, rp);
            chk($sformatf("tbl%0d_acc", i), 64'(na), 64'd1);
            chk($sformatf("tbl%0d_send", i), 64'(ns), 64'(tbl[i].exp_send));
            if (tbl[i].exp_send) begin
                chk($sformatf("tbl%0d_dly", i), 64'(dl), 64'd2);
                chk($sformatf("tbl%0d_type", i), 64'(rt), 64'd2);
                chk($sformatf("tbl%0d_src", i), 64'(rs), 64'(tbl[i].src));
                chk($sformatf("tbl%0d_addr", i), 64'(ra), 64'd0);
                chk($sformatf("tbl%0d_data", i), rp, tbl[i].exp_data);
            end
            chk($sformatf("tbl%0d_err", i), 64'(error_count),
                64'(tbl[i].exp_err));
        end

        for (int i = 0; i < 200; i++) begin
            typ = 2'($urandom_range(0, 9) < 4 ? 1 :
                     ($urandom_range(0, 9) < 8 ? 0 : $urandom_range(2, 3)));
            if ($urandom_range(0, 9) == 0) addr = $urandom_range(256, 1000);
            else addr = $urandom_range(0, 15);
            if (typ == 0 && addr < 256 && !vld[addr[7:0]]) typ = 2'd1;
            op(typ, 4'($urandom), addr, {$urandom, $urandom},
               $sformatf("rnd%0d", i));
        end

        // Response held off by resp_busy for four RESP cycles.
        model(2'd0, 32'd0, 64'd0, es, ed);
        @(negedge clk);
        bus.resp_busy   = 1'b1;
        bus.req_busy    = 1'b1;
        bus.req_type    = 2'd0;
        bus.req_source  = 4'd11;
        bus.req_address = 32'd0;
        wait_acc("hold");
        bus.req_busy = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("hold%0d_send", k), 64'(bus.resp_send), 64'd0);
            chk($sformatf("hold%0d_data", k), bus.resp_payload, ed);
            chk($sformatf("hold%0d_src", k), 64'(bus.resp_source), 64'd11);
            chk($sformatf("hold%0d_type", k), 64'(bus.resp_type), 64'd2);
        end
        bus.resp_busy = 1'b0;
        #1;
        chk("hold_send", 64'(bus.resp_send), 64'd1);
        chk("hold_data", bus.resp_payload, ed);
        chk("hold_src", 64'(bus.resp_source), 64'd11);
        @(negedge clk);
        #1;
        chk("hold_once", 64'(bus.resp_send), 64'd0);

        // req_busy left high across a read: no accept until back in IDLE.
        model(2'd0, 32'd10, 64'd0, es, ed);
        @(negedge clk);
        bus.req_busy    = 1'b1;
        bus.req_type    = 2'd0;
        bus.req_source  = 4'd2;
        bus.req_address = 32'd10;
        wait_acc("busy");
        acc2 = -1;
        snd  = -1;
        for (int c = 1; c <= 10 && acc2 < 0; c++) begin
            @(negedge clk);
            #1;
            if (bus.req_accept) acc2 = c;
            if (bus.resp_send && snd < 0) snd = c;
        end
        bus.req_busy = 1'b0;
        chk("busy_snd", 64'(snd), 64'd2);
        chk("busy_reacc", 64'(acc2), 64'd4);
        snd = -1;
        for (int c = 1; c <= 10 && snd < 0; c++) begin
            @(negedge clk);
            #1;
            if (bus.resp_send) snd = c;
        end
        chk("busy_drain", 64'(snd), 64'd2);

        // Reset pulse while the read sits in WAIT.
        @(negedge clk);
        bus.req_busy    = 1'b1;
        bus.req_type    = 2'd0;
        bus.req_source  = 4'd3;
        bus.req_address = 32'd10;
        wait_acc("rstw");
        bus.req_busy = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("rstw_accept", 64'(bus.req_accept), 64'd0);
        chk("rstw_send", 64'(bus.resp_send), 64'd0);
        chk("rstw_type", 64'(bus.resp_type), 64'd0);
        chk("rstw_src", 64'(bus.resp_source), 64'd0);
        chk("rstw_data", bus.resp_payload, 64'd0);
        chk("rstw_err", 64'(error_count), 64'd0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        err_m = 0;
        ns = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            if (bus.resp_send) ns++;
        end
        chk("rstw_nosend", 64'(ns), 64'd0);
        op(2'd0, 4'd3, 32'd10, 64'd0, "rstw_after");

        for (int i = 0; i < 260; i++) begin
            op(2'($urandom_range(2, 3)), 4'd1, 32'($urandom_range(0, 9)),
               64'd0, $sformatf("ill%0d", i));
        end
        chk("err_sat", 64'(error_count), 64'd255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/memory_bus_responder.md
MEMORY_BUS_RESPONDER -- requirements
Module: memory_bus_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory_address_t width.
REQ-002 SHALL have parameter DATA_W, default 64, bus_packet_payload_t width.
REQ-003 SHALL have parameter ID_W, default 4, BusID width.
REQ-004 SHALL have parameter MEM_WORDS, default 256, word-addressed backing store depth (power of two).
REQ-005 SHALL have parameter READ_LATENCY, default 2, cycles from accept to earliest response (legal range 1..15).
REQ-006 clk  in  1  sole clock, all state on rising edge.
REQ-007 reset_n  in  1  reset, asynchronous, active-low.
REQ-008 req_busy  in  1  request slot occupied (request_busy).
REQ-009 req_type  in  2  BusPacketType: 0 bus_read_data, 1 bus_write_data, 2 bus_read_response, 3 reserved.
REQ-010 req_source  in  ID_W  requesting BusID.
REQ-011 req_address  in  ADDR_W  word address.
REQ-012 req_payload  in  DATA_W  write data.
REQ-013 req_accept  out  1  one-cycle pulse; bus clears req_busy on it (accept_request).
REQ-014 resp_busy  in  1  response slot occupied (response_busy).
REQ-015 resp_send  out  1  one-cycle pulse; bus loads response slot and sets resp_busy (send_read_response).
REQ-016 resp_type / resp_source / resp_address / resp_payload  out  2 / ID_W / ADDR_W / DATA_W  response packet fields.
REQ-017 error_count  out  8  saturating count of illegal/out-of-range requests.

Function
REQ-018 FSM states SHALL be IDLE, EXEC, WAIT, RESP.
REQ-019 In IDLE with req_busy=1 at edge T, SHALL latch the request fields, drive req_accept=1 during T+1 only, and enter EXEC.
REQ-020 req_accept SHALL be 0 in every state other than the single EXEC cycle; req_busy is ignored outside IDLE.
REQ-021 EXEC, write (type 1), address < MEM_WORDS: SHALL write req_payload to mem[address] at end of EXEC, then IDLE; no response.
REQ-022 EXEC, read (type 0): SHALL load latency counter with READ_LATENCY-1, read mem[address] (0 if out of range), enter WAIT (RESP directly if READ_LATENCY=1).
REQ-023 WAIT SHALL decrement counter each cycle and enter RESP when it reaches 0.
REQ-024 RESP: SHALL pulse resp_send for exactly one cycle, in the first RESP cycle where resp_busy=0, then IDLE; earliest resp_send is READ_LATENCY cycles after the req_accept cycle.
REQ-025 Response SHALL be resp_type=2, resp_source=latched req_source, resp_address=0, resp_payload=read data; fields SHALL remain stable from RESP entry through the resp_send cycle.
REQ-026 While resp_busy=1 in RESP, SHALL hold indefinitely without dropping or changing data.
REQ-027 Address >= MEM_WORDS SHALL increment error_count; writes dropped, reads respond with payload 0.
REQ-028 req_type 2 or 3 SHALL be accepted, produce no response and no write, increment error_count, return to IDLE.
REQ-029 error_count SHALL saturate at 255.
REQ-030 A write followed immediately by a read of the same address SHALL return the new data.
REQ-031 Throughput: at most one request in flight; minimum request-to-request spacing 2 cycles for writes.

Reset
REQ-032 reset_n=0 SHALL immediately force IDLE, req_accept=0, resp_send=0, resp_type/source/address/payload=0, error_count=0, counter=0.
REQ-033 Backing memory contents SHALL NOT be reset.
REQ-034 Reset during EXEC/WAIT/RESP SHALL abandon the transaction: no resp_send after reset release; a write in EXEC at assertion is not guaranteed.

Verification
REQ-035 Write addr 5 payload 0xDEAD from source 1, then read addr 5 from source 3 -> req_accept one pulse each; resp_send exactly 2 cycles after read accept with type 2, source 3, address 0, payload 0xDEAD.
REQ-036 Read with resp_busy held 1 for 4 cycles after RESP entry -> resp_send fires on first cycle resp_busy=0, fields unchanged throughout.
REQ-037 Read addr 300 (MEM_WORDS=256) -> response payload 0, error_count=1; write addr 300 -> no memory change, error_count=2.
REQ-038 Request type 2 -> req_accept pulses, no resp_send, error_count increments; 260 illegal requests -> error_count=255.
REQ-039 req_busy held 1 throughout a read's WAIT/RESP -> req_accept stays 0 until back in IDLE.
REQ-040 reset_n pulsed low during WAIT -> all outputs 0 asynchronously, no resp_send after release, next request served normally.
